// File: rtl/unit_arb_pkg.sv
// Shared constants for the request arbiter: opcodes, FSM encodings, datapath widths
// and the round-robin index helper.
package unit_arb_pkg;

    localparam int OPND_W = 16;
    localparam int RES_W  = 8;

    localparam logic [2:0] OP_CMP   = 3'd0;
    localparam logic [2:0] OP_PENC  = 3'd1;
    localparam logic [2:0] OP_MUX   = 3'd2;
    localparam logic [2:0] OP_WMAJ  = 3'd3;
    localparam logic [2:0] OP_PIECE = 3'd4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Requester visited at search step 'offset' after the previous winner
    function automatic int rrIndex(input int last, input int offset, input int n);
        return (last + offset) % n;
    endfunction

endpackage

// File: rtl/unit_request_arbiter_rr.sv
// Combinational round-robin picker: searches upward from last_grant_i+1 with wrap.
module rr_arbiter
    import unit_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    last_grant_i,
    output logic               grant_valid_o,
    output logic [ID_W-1:0]    grant_idx_o,
    output logic [NUM_REQ-1:0] grant_onehot_o
);
    // Walk from lowest priority to highest so the nearest active requester wins
    always_comb begin
        grant_valid_o  = 1'b0;
        grant_idx_o    = '0;
        grant_onehot_o = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            automatic int idx = rrIndex(int'(last_grant_i), k, NUM_REQ);
            if (|(req_i & (NUM_REQ'(1) << idx))) begin
                grant_valid_o  = 1'b1;
                grant_idx_o    = ID_W'(idx);
                grant_onehot_o = NUM_REQ'(1) << idx;
            end
        end
    end
endmodule

// File: rtl/unit_request_arbiter_units.sv
// The five combinational practice arithmetic units shared by all requesters.

module comparator (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       less,
    output logic       more,
    output logic       equal,
    output logic       one_bit_diff
);
    logic [3:0] diffBits;

    assign diffBits     = a ^ b;
    assign less         = a < b;
    assign more         = a > b;
    assign equal        = a == b;
    assign one_bit_diff = (diffBits != 4'd0) && ((diffBits & (diffBits - 4'd1)) == 4'd0);
endmodule

module priority_encoder (
    input  logic [15:0] in_value,
    output logic [3:0]  most_significant_bit,
    output logic        multiple_ones
);
    // Ascending scan so the highest set bit is the last one written
    always_comb begin
        most_significant_bit = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (in_value[i]) begin
                most_significant_bit = i[3:0];
            end
        end
    end

    assign multiple_ones = $countones(in_value) > 1;
endmodule

module multiplexer (
    input  logic [7:0] input_values,
    input  logic [2:0] selector,
    output logic       out_value
);
    assign out_value = input_values[selector];
endmodule

module weighted_majority (
    input  logic [5:0] inputs,
    input  logic [5:0] doubles,
    output logic       result
);
    logic [4:0] setWeight;
    logic [4:0] totalWeight;

    // A doubled voter weighs 2, otherwise 1; strict majority of total weight wins
    always_comb begin
        setWeight   = 5'd0;
        totalWeight = 5'd0;
        for (int i = 0; i < 6; i++) begin
            totalWeight = totalWeight + (doubles[i] ? 5'd2 : 5'd1);
            if (inputs[i]) begin
                setWeight = setWeight + (doubles[i] ? 5'd2 : 5'd1);
            end
        end
    end

    assign result = {setWeight, 1'b0} > {1'b0, totalWeight};
endmodule

module piecewise_combination (
    input  logic [3:0] input1,
    input  logic [3:0] input2,
    output logic [7:0] combination_result
);
    always_comb begin
        if (input1 > input2) begin
            combination_result = {4'd0, input1} * {4'd0, input2};
        end else if (input1 == input2) begin
            combination_result = {input1, input2};
        end else begin
            combination_result = {4'd0, input2 - input1};
        end
    end
endmodule

// File: rtl/unit_request_arbiter.sv
// Time-shares one set of arithmetic units among NUM_REQ requesters (IDLE/EXEC/RESP).
// Define UNIT_ARB_STATS_EN to add the saturating served_count output.
module unit_request_arbiter
    import unit_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [3*NUM_REQ-1:0]     req_op,
    input  logic [OPND_W*NUM_REQ-1:0] req_a,
    input  logic [OPND_W*NUM_REQ-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [RES_W-1:0]         rsp_data,
    output logic                     rsp_err
`ifdef UNIT_ARB_STATS_EN
    ,
    output logic [15:0]              served_count
`endif
);
    logic [1:0]        state_q, state_d;
    logic [ID_W-1:0]   lastGrant_q, lastGrant_d;
    logic [2:0]        curOp_q, curOp_d;
    logic [OPND_W-1:0] curA_q, curA_d;
    logic [OPND_W-1:0] curB_q, curB_d;
    logic [ID_W-1:0]   curId_q, curId_d;
    logic              rspValid_q, rspValid_d;
    logic [ID_W-1:0]   rspId_q, rspId_d;
    logic [RES_W-1:0]  rspData_q, rspData_d;
    logic              rspErr_q, rspErr_d;

    logic               grantValid;
    logic [ID_W-1:0]    grantIdx;
    logic [NUM_REQ-1:0] grantOnehot;

    logic              cmpLess, cmpMore, cmpEqual, cmpOneBit;
    logic [3:0]        pencMsb;
    logic              pencMulti;
    logic              muxOut;
    logic              wmajOut;
    logic [7:0]        pieceOut;
    logic [RES_W-1:0]  unitResult;
    logic              unitErr;
    logic              unusedBBits;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
        .req_i          (req_valid),
        .last_grant_i   (lastGrant_q),
        .grant_valid_o  (grantValid),
        .grant_idx_o    (grantIdx),
        .grant_onehot_o (grantOnehot)
    );

    comparator u_cmp (
        .a(curA_q[3:0]), .b(curB_q[3:0]),
        .less(cmpLess), .more(cmpMore), .equal(cmpEqual), .one_bit_diff(cmpOneBit)
    );

    priority_encoder u_penc (
        .in_value(curA_q), .most_significant_bit(pencMsb), .multiple_ones(pencMulti)
    );

    multiplexer u_mux (
        .input_values(curA_q[7:0]), .selector(curB_q[2:0]), .out_value(muxOut)
    );

    weighted_majority u_wmaj (
        .inputs(curA_q[5:0]), .doubles(curB_q[5:0]), .result(wmajOut)
    );

    piecewise_combination u_piece (
        .input1(curA_q[3:0]), .input2(curB_q[3:0]), .combination_result(pieceOut)
    );

    assign unusedBBits = ^curB_q[OPND_W-1:6];

    always_comb begin
        unitResult = '0;
        unitErr    = 1'b0;
        case (curOp_q)
            OP_CMP:   unitResult = {4'd0, cmpLess, cmpMore, cmpEqual, cmpOneBit};
            OP_PENC:  unitResult = {3'd0, pencMulti, pencMsb};
            OP_MUX:   unitResult = {7'd0, muxOut};
            OP_WMAJ:  unitResult = {7'd0, wmajOut};
            OP_PIECE: unitResult = pieceOut;
            default:  unitErr    = 1'b1;
        endcase
    end

    // Accept strobe exists only in IDLE and is suppressed while reset is applied
    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        curOp_d     = curOp_q;
        curA_d      = curA_q;
        curB_d      = curB_q;
        curId_d     = curId_q;
        rspValid_d  = rspValid_q;
        rspId_d     = rspId_q;
        rspData_d   = rspData_q;
        rspErr_d    = rspErr_q;
        req_ready   = '0;
        case (state_q)
            ST_IDLE: begin
                if (grantValid) begin
                    req_ready = grantOnehot;
                    curOp_d   = req_op[3*grantIdx +: 3];
                    curA_d    = req_a[OPND_W*grantIdx +: OPND_W];
                    curB_d    = req_b[OPND_W*grantIdx +: OPND_W];
                    curId_d   = grantIdx;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rspData_d  = unitResult;
                rspErr_d   = unitErr;
                rspId_d    = curId_q;
                rspValid_d = 1'b1;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rspValid_d  = 1'b0;
                    lastGrant_d = curId_q;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (reset) begin
            req_ready = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            lastGrant_q <= ID_W'(NUM_REQ - 1);
            curOp_q     <= '0;
            curA_q      <= '0;
            curB_q      <= '0;
            curId_q     <= '0;
            rspValid_q  <= 1'b0;
            rspId_q     <= '0;
            rspData_q   <= '0;
            rspErr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            curOp_q     <= curOp_d;
            curA_q      <= curA_d;
            curB_q      <= curB_d;
            curId_q     <= curId_d;
            rspValid_q  <= rspValid_d;
            rspId_q     <= rspId_d;
            rspData_q   <= rspData_d;
            rspErr_q    <= rspErr_d;
        end
    end

    assign rsp_valid = rspValid_q;
    assign rsp_id    = rspId_q;
    assign rsp_data  = rspData_q;
    assign rsp_err   = rspErr_q;

`ifdef UNIT_ARB_STATS_EN
    logic [15:0] servedCount_q;

    // Counts every completed response, error responses included, saturating
    always_ff @(posedge clk) begin
        if (reset) begin
            servedCount_q <= '0;
        end else if (state_q == ST_RESP && rsp_ready && servedCount_q != 16'hFFFF) begin
            servedCount_q <= servedCount_q + 16'd1;
        end
    end

    assign served_count = servedCount_q;
`endif

endmodule
